// File: rtl/layer_sequencer.sv
// Multi-layer ConvAcc sequencer: walks a programmable mode table and ping-pongs the
// InOut banks between layers. Each layer is guarded by a watchdog and can be aborted.

module layer_sequencer_checker #(
  parameter int NUM_LAYERS = 8,
  parameter int LAYER_W    = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               acc_start,
  input logic               finish,
  input logic               busy,
  input logic [LAYER_W-1:0] layer_idx
);

  a_start_pulse: assert property (@(posedge clk) disable iff (rst) acc_start |=> !acc_start);
  a_start_busy:  assert property (@(posedge clk) disable iff (rst) acc_start |-> busy);
  a_no_overlap:  assert property (@(posedge clk) disable iff (rst) !(acc_start && finish));
  a_idx_range:   assert property (@(posedge clk) disable iff (rst) layer_idx < LAYER_W'(NUM_LAYERS));

endmodule

module layer_sequencer #(
  parameter int NUM_LAYERS = 8,
  parameter int MODE_W     = 4,
  parameter int TIMEOUT    = 1048576,
  parameter int LAYER_W    = $clog2(NUM_LAYERS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [LAYER_W-1:0] num_layers_i,
  input  logic               abort_i,
  input  logic               cfg_we_i,
  input  logic [LAYER_W-1:0] cfg_idx_i,
  input  logic [MODE_W-1:0]  cfg_mode_i,
  output logic               acc_start_o,
  output logic [MODE_W-1:0]  acc_mode_o,
  input  logic               acc_finish_i,
  output logic               bank_sel_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic               busy_o,
  output logic               finish_o,
  output logic               error_o
);

  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TBL_D = 1 << LAYER_W;
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [LAYER_W-1:0] MAX_LAYERS = LAYER_W'(NUM_LAYERS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_SWAP   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t state_r, state_s;

  // Table is sized to the full index range so any index value addresses it;
  // entries at or above NUM_LAYERS are never written and stay zero.
  logic [MODE_W-1:0]  mode_tbl_r [TBL_D];
  logic [LAYER_W-1:0] count_r, count_s;
  logic [LAYER_W-1:0] layer_idx_r, layer_idx_s, next_idx_s;
  logic               bank_sel_r, bank_sel_s;
  logic [WD_W-1:0]    wd_r, wd_s;
  logic [MODE_W-1:0]  acc_mode_r, acc_mode_s, launch_mode_s;
  logic               acc_start_r, finish_r, busy_r;
  logic               error_r, error_s;
  logic               accept_s, zero_start_s, tbl_we_s, last_s;

  // Host-side request decode; start and table writes are only honoured in IDLE.
  always_comb begin
    accept_s     = 1'b0;
    zero_start_s = 1'b0;
    tbl_we_s     = 1'b0;
    if (state_r == S_IDLE) begin
      accept_s     = start_i && (num_layers_i != LAYER_W'(0));
      zero_start_s = start_i && (num_layers_i == LAYER_W'(0));
      tbl_we_s     = cfg_we_i && (cfg_idx_i < MAX_LAYERS);
    end else begin
      accept_s     = 1'b0;
      zero_start_s = 1'b0;
      tbl_we_s     = 1'b0;
    end
    next_idx_s = layer_idx_r + LAYER_W'(1);
    last_s     = (layer_idx_r == (count_r - LAYER_W'(1)));
  end

  // Next-state selection; abort outranks completion and watchdog expiry.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_LAUNCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LAUNCH: begin
        if (abort_i) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          state_s = S_IDLE;
        end else if (acc_finish_i) begin
          if (last_s) begin
            state_s = S_DONE;
          end else begin
            state_s = S_SWAP;
          end
        end else if (wd_r == WD_LAST) begin
          state_s = S_ERR;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_SWAP: begin
        if (abort_i) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_LAUNCH;
        end
      end
      S_DONE:  state_s = S_IDLE;
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Run bookkeeping: layer count, index, bank, watchdog, error and launch mode.
  always_comb begin
    count_s       = count_r;
    layer_idx_s   = layer_idx_r;
    bank_sel_s    = bank_sel_r;
    error_s       = error_r;
    launch_mode_s = acc_mode_r;
    if (accept_s) begin
      count_s     = (num_layers_i > MAX_LAYERS) ? MAX_LAYERS : num_layers_i;
      layer_idx_s = LAYER_W'(0);
      bank_sel_s  = 1'b0;
      error_s     = 1'b0;
      // A same-cycle write to entry 0 must be visible to the first layer.
      if (tbl_we_s && (cfg_idx_i == LAYER_W'(0))) begin
        launch_mode_s = cfg_mode_i;
      end else begin
        launch_mode_s = mode_tbl_r[LAYER_W'(0)];
      end
    end else if ((state_r == S_SWAP) && (state_s == S_LAUNCH)) begin
      layer_idx_s   = next_idx_s;
      bank_sel_s    = ~bank_sel_r;
      launch_mode_s = mode_tbl_r[next_idx_s];
    end else begin
      launch_mode_s = acc_mode_r;
    end
    if (state_s == S_LAUNCH) begin
      acc_mode_s = launch_mode_s;
    end else begin
      acc_mode_s = acc_mode_r;
    end
    if (state_s == S_ERR) begin
      error_s = 1'b1;
    end else begin
      error_s = error_s;
    end
    if (state_r == S_WAIT) begin
      wd_s = wd_r + WD_W'(1);
    end else begin
      wd_s = WD_W'(0);
    end
  end

  // State, mode table and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      mode_tbl_r  <= '{default: MODE_W'(0)};
      count_r     <= LAYER_W'(0);
      layer_idx_r <= LAYER_W'(0);
      bank_sel_r  <= 1'b0;
      wd_r        <= WD_W'(0);
      acc_mode_r  <= MODE_W'(0);
      acc_start_r <= 1'b0;
      finish_r    <= 1'b0;
      busy_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      if (tbl_we_s) begin
        mode_tbl_r[cfg_idx_i] <= cfg_mode_i;
      end
      count_r     <= count_s;
      layer_idx_r <= layer_idx_s;
      bank_sel_r  <= bank_sel_s;
      wd_r        <= wd_s;
      acc_mode_r  <= acc_mode_s;
      acc_start_r <= (state_s == S_LAUNCH);
      finish_r    <= (state_s == S_DONE) || zero_start_s;
      busy_r      <= (state_s != S_IDLE);
      error_r     <= error_s;
    end
  end

  assign acc_start_o = acc_start_r;
  assign acc_mode_o  = acc_mode_r;
  assign bank_sel_o  = bank_sel_r;
  assign layer_idx_o = layer_idx_r;
  assign busy_o      = busy_r;
  assign finish_o    = finish_r;
  assign error_o     = error_r;

  layer_sequencer_checker #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_W    (LAYER_W)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .acc_start (acc_start_r),
    .finish    (finish_r),
    .busy      (busy_r),
    .layer_idx (layer_idx_r)
  );

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Parametrised successor to the single-shot accelerator top; chains up to NUM_LAYERS ConvAcc runs from one start.
- Per-layer mode comes from a programmable mode table.
- Ping-pong swaps the two InOut SRAM banks between layers, so each layer's output becomes the next layer's input.
- Adds a per-layer watchdog and abort; sits between the host start/finish and ConvAcc start/mode/finish.

Parameters:
- NUM_LAYERS, 8: mode-table depth and maximum layers per run.
- MODE_W, 4: width of the ConvAcc mode field.
- TIMEOUT, 1048576: maximum cycles per layer in WAIT before error.
- LAYER_W, $clog2(NUM_LAYERS+1): width of the layer count and index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  run request; sampled in IDLE only
- num_layers_i  in  LAYER_W  layers to run; sampled with start_i
- abort_i  in  1  cancel the current run
- cfg_we_i  in  1  mode-table write enable
- cfg_idx_i  in  LAYER_W  mode-table write index
- cfg_mode_i  in  MODE_W  mode-table write data
- acc_start_o  out  1  one-cycle start pulse to ConvAcc
- acc_mode_o  out  MODE_W  mode for the current layer
- acc_finish_i  in  1  ConvAcc completion pulse
- bank_sel_o  out  1  0: bank A = input, bank B = output; 1: swapped
- layer_idx_o  out  LAYER_W  current layer index
- busy_o  out  1  high outside IDLE
- finish_o  out  1  one-cycle run-complete pulse
- error_o  out  1  sticky watchdog error

Behaviour:
- Reset (rst high at a clk edge): state IDLE. All outputs 0: acc_start_o, acc_mode_o, bank_sel_o, layer_idx_o, busy_o, finish_o, error_o. Mode table cleared to 0. Watchdog counter 0.
- IDLE:
  - start_i=1 with num_layers_i in 1..NUM_LAYERS: latch count, layer_idx=0, bank_sel=0, clear error_o -> LAUNCH.
  - num_layers_i=0: finish_o=1 next cycle, stay IDLE, no acc_start_o.
  - num_layers_i>NUM_LAYERS: clamp to NUM_LAYERS.
- LAUNCH (exactly one cycle):
  - acc_start_o=1; acc_mode_o=mode_tbl[layer_idx]; watchdog cleared -> WAIT.
  - acc_mode_o stays valid through WAIT.
- WAIT:
  - acc_finish_i=1 and layer_idx==count-1 -> DONE.
  - acc_finish_i=1 otherwise -> SWAP.
  - Watchdog counts every WAIT cycle; reaching TIMEOUT-1 without acc_finish_i -> ERR.
- SWAP (one cycle): bank_sel_o toggles, layer_idx increments -> LAUNCH.
- DONE (one cycle): finish_o=1 -> IDLE. bank_sel_o and layer_idx_o hold (bank_sel_o marks the bank holding the final output) until the next start.
- ERR (one cycle): error_o set (sticky until next accepted start), no finish_o -> IDLE.
- Latency:
  - start_i at cycle 0 -> acc_start_o at cycle 1.
  - acc_finish_i at cycle N -> next acc_start_o at N+2 (intermediate layer) or finish_o at N+1 (last layer).
- acc_finish_i is ignored outside WAIT; a pulse coincident with acc_start_o does not count.
- abort_i (any non-IDLE state) -> IDLE next cycle. No finish_o, error_o unchanged, bank_sel_o and layer_idx_o hold. abort_i has priority over acc_finish_i and over watchdog expiry in the same cycle.
- cfg_we_i:
  - Writes the table only in IDLE; ignored while busy_o=1.
  - cfg_idx_i>=NUM_LAYERS is ignored.
  - start_i and cfg_we_i in the same cycle: the write lands first, so the first layer uses the new mode if idx=0.
- start_i while busy: ignored.
- rst mid-run: immediate return to IDLE with reset values; the mode table is cleared.

Test Plan:
- Program modes {3,5,7}, start with num_layers=3, model finish 10 cycles after each start -> 3 acc_start_o pulses with modes 3,5,7; bank_sel_o sequence 0,1,0; finish_o once; final bank_sel_o=0.
- num_layers=1, mode 2 -> single launch, finish_o exactly 1 cycle after acc_finish_i, bank_sel_o stays 0.
- num_layers=0 -> finish_o the cycle after start, no acc_start_o, busy_o stays 0.
- TIMEOUT=16, ConvAcc never finishes -> error_o rises after 16 WAIT cycles, no finish_o; next start clears error_o.
- abort_i during layer 2 of 4, same cycle as acc_finish_i -> IDLE, no further acc_start_o, no finish_o, layer_idx_o holds 1.
- cfg_we_i while busy (idx 0, mode 9) -> table unchanged; rerun shows the original mode. rst during WAIT -> all outputs 0 next cycle.
